// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the CPU data memory; one word access per IDLE-ACCESS-RESP pass.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority with port 0 first.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES   = 256,
  parameter bit          ZERO_WR_ERR = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        mRD,
  output logic        mWR,
  output logic [31:0] DAddr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic             mrd_q, mrd_d;
  logic             mwr_q, mwr_d;
  logic [31:0]      daddr_q, daddr_d;
  logic [31:0]      datain_q, datain_d;

  logic             gnt;
  logic             sel_we;
  logic             sel_bad;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic             last_owner_q, last_owner_d;
`endif

  // Winner selection and address validation for the request being sampled in IDLE.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    if (r0_req && r1_req) begin
      gnt = ~last_owner_q;
    end else begin
      gnt = ~r0_req;
    end
`else
    gnt = ~r0_req;
`endif
    sel_we    = gnt ? r1_we    : r0_we;
    sel_addr  = gnt ? r1_addr  : r0_addr;
    sel_wdata = gnt ? r1_wdata : r0_wdata;
    sel_bad   = (sel_addr[1:0] != 2'b00)
             || (sel_addr > MAX_ADDR)
             || (ZERO_WR_ERR && sel_we && (sel_addr == '0));
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    ack_d    = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    daddr_d  = '0;
    datain_d = '0;
`ifdef DMEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          owner_d = gnt;
          we_d    = sel_we;
`ifdef DMEM_ARB_RR_EN
          last_owner_d = gnt;
`endif
          // Memory strobes are registered, so they are set up here to be live during ACCESS.
          if (sel_bad) begin
            state_d    = RESP;
            ack_d[gnt] = 1'b1;
            err_d[gnt] = 1'b1;
          end else begin
            state_d  = ACCESS;
            mrd_d    = ~sel_we;
            mwr_d    = sel_we;
            daddr_d  = sel_addr;
            datain_d = sel_wdata;
          end
        end
      end
      ACCESS: begin
        state_d        = RESP;
        ack_d[owner_q] = 1'b1;
        if (!we_q) begin
          rdata_d[owner_q] = DataOut;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      ack_q    <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      daddr_q  <= '0;
      datain_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      daddr_q  <= daddr_d;
      datain_q <= datain_d;
`ifdef DMEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  assign r0_rdata = rdata_q[0];
  assign r1_rdata = rdata_q[1];
  assign mRD      = mrd_q;
  assign mWR      = mwr_q;
  assign DAddr    = daddr_q;
  assign DataIn   = datain_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-byte little-endian data memory.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        r0_req, r0_we, r0_ack, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_ack, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mRD, mWR;
  logic [31:0] DAddr, DataIn, DataOut;

  int nchk = 0;
  int nerr = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
`ifdef DMEM_ARB_RR_EN
  int tb_last = 1;
`endif

  logic [7:0] mem [256] = '{default: 8'h00};

  always #5 CLK = ~CLK;

  dmem_arbiter #(.MEM_BYTES(256), .ZERO_WR_ERR(1'b1)) dut (
    .CLK(CLK), .Reset(Reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mRD(mRD), .mWR(mWR), .DAddr(DAddr), .DataIn(DataIn), .DataOut(DataOut)
  );

  // Memory: writes on negedge (address 0 dropped), combinational read gated by mRD.
  always @(negedge CLK) begin
    if (mRD) rd_cnt++;
    if (mWR) wr_cnt++;
    if (mWR && DAddr != 32'd0 && DAddr <= 32'd252) begin
      mem[DAddr[7:0]]         <= DataIn[7:0];
      mem[DAddr[7:0] + 8'd1]  <= DataIn[15:8];
      mem[DAddr[7:0] + 8'd2]  <= DataIn[23:16];
      mem[DAddr[7:0] + 8'd3]  <= DataIn[31:24];
    end
  end

  always_comb begin
    DataOut = '0;
    if (mRD && DAddr <= 32'd252)
      DataOut = {mem[DAddr[7:0] + 8'd3], mem[DAddr[7:0] + 8'd2],
                 mem[DAddr[7:0] + 8'd1], mem[DAddr[7:0]]};
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int win(input bit a, input bit b);
    if (a && b) begin
`ifdef DMEM_ARB_RR_EN
      return (tb_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return a ? 0 : 1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_r0_ack"}, 32'(r0_ack), 32'd0);
    chk({tag, "_r1_ack"}, 32'(r1_ack), 32'd0);
    chk({tag, "_r0_err"}, 32'(r0_err), 32'd0);
    chk({tag, "_r1_err"}, 32'(r1_err), 32'd0);
    chk({tag, "_r0_rdata"}, r0_rdata, 32'd0);
    chk({tag, "_r1_rdata"}, r1_rdata, 32'd0);
    chk({tag, "_mRD"}, 32'(mRD), 32'd0);
    chk({tag, "_mWR"}, 32'(mWR), 32'd0);
    chk({tag, "_DAddr"}, DAddr, 32'd0);
    chk({tag, "_DataIn"}, DataIn, 32'd0);
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int rd0 = rd_cnt;
    int wr0 = wr_cnt;
    int n = 0;
    bit got = 0;
    string tag = $sformatf("v%0d", idx);
    if (v.port) begin
      r1_req = 1'b1; r1_we = v.we; r1_addr = v.addr; r1_wdata = v.wdata;
    end else begin
      r0_req = 1'b1; r0_we = v.we; r0_addr = v.addr; r0_wdata = v.wdata;
    end
    while (!got && n < 8) begin
      @(posedge CLK); #1;
      n++;
      if (r0_ack || r1_ack) got = 1;
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    chk({tag, "_ack_port"}, {30'd0, r1_ack, r0_ack}, v.port ? 32'd2 : 32'd1);
    chk({tag, "_err"}, 32'(v.port ? r1_err : r0_err), 32'(v.exp_err));
    chk({tag, "_rdata"}, v.port ? r1_rdata : r0_rdata, v.exp_rdata);
    chk({tag, "_latency"}, 32'(n), v.exp_err ? 32'd1 : 32'd2);
    chk({tag, "_wr_cycles"}, 32'(wr_cnt - wr0), (!v.exp_err && v.we) ? 32'd1 : 32'd0);
    chk({tag, "_rd_cycles"}, 32'(rd_cnt - rd0), (!v.exp_err && !v.we) ? 32'd1 : 32'd0);
`ifdef DMEM_ARB_RR_EN
    tb_last = int'(v.port);
`endif
    @(posedge CLK); #1;
    chk({tag, "_ack_pulse"}, 32'({r0_ack, r1_ack}), 32'd0);
  endtask

  // Both ports request reads in the same IDLE cycle.
  task automatic tie_seq(input int idx);
    int w = win(1'b1, 1'b1);
    int t0 = (w == 0) ? 2 : 5;
    int t1 = (w == 1) ? 2 : 5;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'hFC;
    for (int n = 1; n <= 7; n++) begin
      @(posedge CLK); #1;
      chk($sformatf("tie%0d_r0_ack_c%0d", idx, n), 32'(r0_ack), 32'(n == t0));
      chk($sformatf("tie%0d_r1_ack_c%0d", idx, n), 32'(r1_ack), 32'(n == t1));
      if (n == t0) begin
        r0_req = 1'b0;
        chk($sformatf("tie%0d_r0_rdata", idx), r0_rdata, 32'hA1B2C3D4);
      end
      if (n == t1) begin
        r1_req = 1'b0;
        chk($sformatf("tie%0d_r1_rdata", idx), r1_rdata, 32'h11223344);
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
`ifdef DMEM_ARB_RR_EN
    tb_last = 1 - w;
`endif
  endtask

  initial begin
    int exp_port [11];
    int rem0, rem1, g, seen0, seen1;
    bit any_ack;

    vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hA1B2C3D4, 1'b0, 32'h00000000};
    vecs[1] = '{1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hA1B2C3D4};
    vecs[2] = '{1'b1, 1'b0, 32'h12,  32'h0,        1'b1, 32'h00000000};
    vecs[3] = '{1'b1, 1'b0, 32'hFE,  32'h0,        1'b1, 32'h00000000};
    vecs[4] = '{1'b1, 1'b1, 32'h00,  32'h55AA55AA, 1'b1, 32'h00000000};
    vecs[5] = '{1'b1, 1'b1, 32'hFC,  32'h11223344, 1'b0, 32'h00000000};
    vecs[6] = '{1'b0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'h11223344};
    vecs[7] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hA1B2C3D4};
    vecs[8] = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'hA1B2C3D4};
    vecs[9] = '{1'b0, 1'b0, 32'h00,  32'h0,        1'b0, 32'h00000000};

    Reset = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_vals("reset");
    Reset = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    chk("mem_0x10", 32'(mem[16]), 32'hD4);
    chk("mem_0x11", 32'(mem[17]), 32'hC3);
    chk("mem_0x12", 32'(mem[18]), 32'hB2);
    chk("mem_0x13", 32'(mem[19]), 32'hA1);
    chk("mem_0x00_untouched", {mem[3], mem[2], mem[1], mem[0]}, 32'h0);

    tie_seq(0);
    tie_seq(1);

    // Port 0 holds req for two acks while port 1 waits; grants at edges 1,4,7 -> acks at 2,5,8.
    for (int i = 0; i < 11; i++) exp_port[i] = -1;
    rem0 = 2; rem1 = 1;
    for (int k = 0; k < 3; k++) begin
      g = win(rem0 > 0, rem1 > 0);
      exp_port[3 * k + 2] = g;
`ifdef DMEM_ARB_RR_EN
      tb_last = g;
`endif
      if (g == 0) rem0--; else rem1--;
    end
    seen0 = 0; seen1 = 0;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'hFC;
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLK); #1;
      chk($sformatf("held_r0_ack_c%0d", n), 32'(r0_ack), 32'(exp_port[n] == 0));
      chk($sformatf("held_r1_ack_c%0d", n), 32'(r1_ack), 32'(exp_port[n] == 1));
      if (r0_ack) begin
        seen0++;
        chk($sformatf("held_r0_rdata_%0d", seen0), r0_rdata, 32'hA1B2C3D4);
        if (seen0 >= 2) r0_req = 1'b0;
      end
      if (r1_ack) begin
        seen1++;
        chk("held_r1_rdata", r1_rdata, 32'h11223344);
        r1_req = 1'b0;
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;

    // Reset asserted while a write is in its ACCESS cycle.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h40; r0_wdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    chk("rst_access_mWR", 32'(mWR), 32'd1);
    chk("rst_access_DAddr", DAddr, 32'h40);
    Reset = 1'b1;
    r0_req = 1'b0;
    @(posedge CLK); #1;
    chk_reset_vals("midrst");
    Reset = 1'b0;
    any_ack = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (r0_ack || r1_ack) any_ack = 1'b1;
    end
    chk("midrst_no_ack", 32'(any_ack), 32'd0);
    chk("midrst_mem_word", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hCAFEF00D);
`ifdef DMEM_ARB_RR_EN
    tb_last = 1;
`endif
    run_vec('{1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 32'hCAFEF00D}, 10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-cycle CPU data memory (256-byte, byte-addressed, little-endian word access, write on CLK negedge, combinational read gated by mRD).
- Port 0 is the CPU load/store unit. Port 1 is a debug/DMA loader.
- Serialises their word requests into one memory access at a time.
- Validates addresses, drives mRD/mWR/DAddr/DataIn, and returns a registered ack, read data and error per port.

Parameters:
- MEM_BYTES, 256: memory size in bytes; highest legal word address is MEM_BYTES-4.
- ZERO_WR_ERR, 1: when 1, a write to address 0 is flagged as an error, because the memory drops writes at address 0.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- r0_req  input  1  port 0 request; held high until r0_ack.
- r0_we  input  1  port 0 direction: 1 = write, 0 = read.
- r0_addr  input  32  port 0 byte address.
- r0_wdata  input  32  port 0 write data.
- r0_ack  output  1  port 0 one-cycle completion pulse.
- r0_rdata  output  32  port 0 read data; valid from the r0_ack cycle.
- r0_err  output  1  port 0 error, valid with r0_ack.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata, r1_err: same as port 0, for port 1.
- mRD  output  1  memory read enable.
- mWR  output  1  memory write enable.
- DAddr  output  32  memory byte address.
- DataIn  output  32  memory write data.
- DataOut  input  32  memory read data.

Behaviour:
- Reset values:
  - state = IDLE.
  - All ack/err = 0; r0_rdata = r1_rdata = 0.
  - mRD = mWR = 0; DAddr = DataIn = 0.
  - owner = 0; last_owner = 1.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Memory outputs are 0.
  - At posedge, if any req is high, pick the winner by arbitration. Latch owner, we, addr and wdata.
  - Invalid request → RESP with err = 1, no memory access. Invalid means any of:
    - addr[1:0] != 0;
    - addr > MEM_BYTES-4;
    - ZERO_WR_ERR and we and addr == 0.
  - Otherwise → ACCESS.
  - No request → stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mRD = ~we; mWR = we; DAddr = latched addr; DataIn = latched wdata.
  - A write completes at the negedge inside this cycle.
  - Read: DataOut is captured into the owner's rdata register at the closing posedge.
  - → RESP.
- RESP (1 cycle):
  - Owner's ack = 1; err is valid; non-owner ack = 0.
  - Memory outputs are 0.
  - → IDLE.
- Latency: request sampled at end of IDLE cycle → ack 2 cycles later. Throughput is one access per 3 cycles; back-to-back requests each take the full 3 cycles.
- rdata for a port holds its last read value. Writes and errored requests leave it unchanged.
- Handshake rules:
  - A requester deasserts req at the posedge that ends its ack cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
  - Dropping req before ack does not cancel a latched transaction; ack is still issued.
- Arbitration (default, fixed priority): port 0 wins simultaneous requests. Port 1 may starve while port 0 is continuously busy; this is accepted for CPU priority.
- Request inputs are ignored outside IDLE; changes to addr/wdata after latching have no effect.
- Reset mid-operation:
  - Next state is IDLE; no ack is issued for the pending transaction.
  - A write whose ACCESS cycle had begun has already reached memory at the negedge and is not undone.
  - rdata registers are cleared.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. On simultaneous requests, grant the port != last_owner.
  - last_owner updates on every grant, including errored grants.
  - Reset value last_owner = 1, so port 0 wins the first tie.
  - A single requester is always granted.
- Undefined: fixed priority as described above; the last_owner register is absent.

Test Plan:
- Port 0 write addr=0x10, wdata=0xA1B2C3D4, then read 0x10 → write ack after 2 cycles with err=0; mWR high for exactly 1 cycle; read ack returns r0_rdata=0xA1B2C3D4; memory bytes 0x10..0x13 = D4,C3,B2,A1.
- Port 0 and port 1 both request reads at the same posedge → fixed build: port 0 acked first, port 1 acked 3 cycles later. DMEM_ARB_RR_EN build: repeat the tie and confirm the grant order alternates 0,1,0,1.
- Port 1 read at addr=0x12, then at 0xFE, then a write at 0x00 → each acked with r1_err=1; mRD and mWR never asserted; r1_rdata unchanged.
- Port 1 write at addr=0xFC, data=0x11223344 → accepted with err=0. A subsequent port 0 read at 0xFC returns 0x11223344.
- Assert Reset during an ACCESS write → no ack pulse; outputs at reset values next cycle; the memory word at that address holds the new data.
- Port 0 keeps req high after ack → a second, identical transaction is issued and acked 3 cycles later; port 1 gets no grant during this sequence (fixed build).
